// File: rtl/lifo_pkg.sv
// Package shared by the LIFO, its frame-reversing controller and the bench.
// Holds the controller state encoding and the default word width / depth.
package lifo_pkg;

  // Controller phases: FILL pushes input words, DRAIN pops them to the output.
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int LIFO_WIDTH = 16;
  localparam int LIFO_DEPTH = 4;

endpackage

// File: rtl/lifo_frame_reverser.sv
// lifo_frame_reverser
//   Sequencer placed in front of a plain LIFO. Input words are pushed until
//   s_last arrives or the LIFO is full. The LIFO is then drained onto the
//   output stream, so every frame (or DEPTH-sized chunk) leaves reversed.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-low reset (shared with the LIFO)
//   s_valid/s_ready/s_data/s_last   input stream
//   m_valid/m_ready/m_data/m_last   output stream (m_data is lifo_data_out)
//   chunk_split    one-cycle pulse: drain started because the LIFO filled
//                  before s_last
//   lifo_push/lifo_pop/lifo_data_in to the LIFO
//   lifo_data_out/lifo_empty/lifo_full from the LIFO
//
// The internal occupancy count is authoritative; lifo_empty and lifo_full
// are only cross-checked by the embedded assertions.
module lifo_frame_reverser
  import lifo_pkg::*;
#(
  parameter int WIDTH = LIFO_WIDTH,
  parameter int DEPTH = LIFO_DEPTH,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             chunk_split,
  output logic             lifo_push,
  output logic             lifo_pop,
  output logic [WIDTH-1:0] lifo_data_in,
  input  logic [WIDTH-1:0] lifo_data_out,
  input  logic             lifo_empty,
  input  logic             lifo_full
);

  localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_DEPTH = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(DEPTH - 1);

  state_e          state_r;
  state_e          state_nxt_s;
  logic [CNTW-1:0] count_r;
  logic [CNTW-1:0] count_nxt_s;
  logic            m_valid_r;
  logic            m_valid_nxt_s;
  logic            last_flag_r;
  logic            last_flag_nxt_s;
  logic            chunk_split_r;
  logic            chunk_split_nxt_s;
  logic            s_ready_s;
  logic            push_s;
  logic            pop_s;

  // Next-state, occupancy and handshake decode for the FILL/DRAIN sequencer.
  always_comb begin
    state_nxt_s       = state_r;
    count_nxt_s       = count_r;
    m_valid_nxt_s     = m_valid_r;
    last_flag_nxt_s   = last_flag_r;
    chunk_split_nxt_s = 1'b0;
    s_ready_s         = 1'b0;
    push_s            = 1'b0;
    pop_s             = 1'b0;
    case (state_r)
      FILL: begin
        // rst gating keeps s_ready low while reset is being sampled.
        s_ready_s = rst & (count_r < CNT_DEPTH);
        push_s    = s_valid & s_ready_s;
        if (push_s) begin
          count_nxt_s = count_r + CNT_ONE;
          // s_last wins over a simultaneous fill: the frame ends naturally.
          if (s_last) begin
            state_nxt_s     = DRAIN;
            last_flag_nxt_s = 1'b1;
          end else if (count_r == CNT_LAST) begin
            state_nxt_s       = DRAIN;
            last_flag_nxt_s   = 1'b0;
            chunk_split_nxt_s = 1'b1;
          end else begin
            state_nxt_s = FILL;
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      DRAIN: begin
        // Pop only when the output register is free or being consumed now;
        // the popped word appears on lifo_data_out one cycle later.
        pop_s = rst & (count_r != CNT_ZERO) & (~m_valid_r | m_ready);
        if (pop_s) begin
          count_nxt_s   = count_r - CNT_ONE;
          m_valid_nxt_s = 1'b1;
        end else if (m_valid_r && m_ready) begin
          m_valid_nxt_s = 1'b0;
          // Final word of the chunk has been accepted.
          if (count_r == CNT_ZERO) begin
            state_nxt_s     = FILL;
            last_flag_nxt_s = 1'b0;
          end else begin
            state_nxt_s = DRAIN;
          end
        end else begin
          m_valid_nxt_s = m_valid_r;
        end
      end
      default: begin
        state_nxt_s     = FILL;
        count_nxt_s     = CNT_ZERO;
        m_valid_nxt_s   = 1'b0;
        last_flag_nxt_s = 1'b0;
      end
    endcase
  end

  // State, occupancy and output-valid registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= FILL;
      count_r       <= CNT_ZERO;
      m_valid_r     <= 1'b0;
      last_flag_r   <= 1'b0;
      chunk_split_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      count_r       <= count_nxt_s;
      m_valid_r     <= m_valid_nxt_s;
      last_flag_r   <= last_flag_nxt_s;
      chunk_split_r <= chunk_split_nxt_s;
    end
  end

  assign s_ready      = s_ready_s;
  assign lifo_push    = push_s;
  assign lifo_pop     = pop_s;
  assign lifo_data_in = s_data;
  assign m_valid      = m_valid_r;
  assign m_data       = lifo_data_out;
  // Only the word presented after the final pop of a real frame is last.
  assign m_last       = last_flag_r & m_valid_r & (count_r == CNT_ZERO);
  assign chunk_split  = chunk_split_r;

  // Occupancy cross-checks against the LIFO's own flags.
  a_full_match : assert property (@(posedge clk) disable iff (!rst)
    lifo_full == (count_r == CNT_DEPTH));
  a_empty_match : assert property (@(posedge clk) disable iff (!rst)
    lifo_empty == (count_r == CNT_ZERO));
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst)
    !(lifo_push && lifo_full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst)
    !(lifo_pop && lifo_empty));
  a_no_push_pop : assert property (@(posedge clk) disable iff (!rst)
    !(lifo_push && lifo_pop));

endmodule

// File: tb/tb_lifo_frame_reverser.sv
// Bench for lifo_frame_reverser: behavioural LIFO, directed steps, a
// reverse-per-chunk scoreboard and a randomised multi-frame run.
module tb_lifo_frame_reverser;
  import lifo_pkg::*;

  localparam int WIDTH = LIFO_WIDTH;
  localparam int DEPTH = LIFO_DEPTH;

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             chunk_split;
  logic             lifo_push;
  logic             lifo_pop;
  logic [WIDTH-1:0] lifo_data_in;
  logic [WIDTH-1:0] lifo_data_out;
  logic             lifo_empty;
  logic             lifo_full;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] chunk_q[$];
  int               split_exp = 0;
  int               split_cnt = 0;
  int               sink_mode = 0;   // 0 ready, 1 pattern 1,0,0, 2 random, 3 stalled

  lifo_frame_reverser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .chunk_split(chunk_split),
    .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_data_in(lifo_data_in),
    .lifo_data_out(lifo_data_out), .lifo_empty(lifo_empty), .lifo_full(lifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural LIFO: pop in cycle t gives data in cycle t+1, held until next pop.
  logic [WIDTH-1:0] mem [DEPTH];
  int ptr;
  always @(posedge clk) begin
    if (!rst) begin
      ptr           <= 0;
      lifo_data_out <= '0;
    end else if (lifo_push && ptr < DEPTH) begin
      mem[ptr] <= lifo_data_in;
      ptr      <= ptr + 1;
    end else if (lifo_pop && ptr > 0) begin
      lifo_data_out <= mem[ptr-1];
      ptr           <= ptr - 1;
    end
  end
  assign lifo_empty = (ptr == 0);
  assign lifo_full  = (ptr == DEPTH);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: collect a chunk, emit it reversed when it ends by s_last or fill.
  task automatic model_accept(input logic [WIDTH-1:0] d, input logic l);
    chunk_q.push_back(d);
    if (l || chunk_q.size() == DEPTH) begin
      for (int i = chunk_q.size() - 1; i >= 0; i--) begin
        exp_q.push_back('{data: chunk_q[i], last: (l && i == 0)});
      end
      if (!l) split_exp++;
      chunk_q.delete();
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int waited = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      check("send_timeout", {31'b0, s_ready}, 32'd1);
      s_valid = 1'b0;
    end else begin
      model_accept(d, l);
      @(posedge clk);
      #1 s_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    #1;
  endtask

  // Sink: drives m_ready, scores handshakes, checks stall stability and flow rules.
  initial begin
    int   pat = 0;
    logic prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    exp_t e;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (sink_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = (pat == 0); pat = (pat + 1) % 3; end
        2: m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b0;
      endcase
      if (sink_mode == 1 && prev_stall) begin
        check("stall_valid", {31'b0, m_valid}, 32'd1);
        check("stall_data", {16'b0, m_data}, {16'b0, prev_data});
        check("stall_last", {31'b0, m_last}, {31'b0, prev_last});
      end
      prev_stall = (sink_mode == 1) && m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {31'b0, m_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {16'b0, m_data}, {16'b0, e.data});
          check("out_last", {31'b0, m_last}, {31'b0, e.last});
        end
      end
      if (rst) begin
        if (m_valid) check("s_ready_in_drain", {31'b0, s_ready}, 32'd0);
        check("no_push_full", {31'b0, lifo_push & lifo_full}, 32'd0);
        check("no_pop_empty", {31'b0, lifo_pop & lifo_empty}, 32'd0);
        check("no_push_pop", {31'b0, lifo_push & lifo_pop}, 32'd0);
      end
      if (chunk_split) split_cnt++;
    end
  end

  initial begin
    logic [WIDTH-1:0] f1 [3];
    logic [WIDTH-1:0] f3 [4];
    int len;
    f1[0] = 16'h0011; f1[1] = 16'h0022; f1[2] = 16'h0033;
    f3[0] = 16'h000A; f3[1] = 16'h000B; f3[2] = 16'h000C; f3[3] = 16'h000D;
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    sink_mode = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", {31'b0, s_ready}, 32'd0);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_last", {31'b0, m_last}, 32'd0);
    check("rst_split", {31'b0, chunk_split}, 32'd0);
    check("rst_push", {31'b0, lifo_push}, 32'd0);
    check("rst_pop", {31'b0, lifo_pop}, 32'd0);
    rst = 1'b1;
    #1 check("idle_s_ready", {31'b0, s_ready}, 32'd1);

    // Three-word frame with latency check
    for (int i = 0; i < 3; i++) send(f1[i], i == 2);
    @(negedge clk);
    check("lat_first_pop", {31'b0, lifo_pop}, 32'd1);
    check("lat_valid_early", {31'b0, m_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'b0, m_valid}, 32'd1);
    wait_drain(50);

    // Six-word frame split into a full chunk plus remainder
    split_cnt = 0; split_exp = 0;
    for (int i = 1; i <= 6; i++) send(WIDTH'(i), i == 6);
    wait_drain(100);
    check("split_count", split_cnt, split_exp);
    check("split_once", split_cnt, 32'd1);

    // Backpressure 1,0,0 pattern
    sink_mode = 1;
    for (int i = 0; i < 4; i++) send(f3[i], i == 3);
    wait_drain(100);
    sink_mode = 0;

    // Single-word frame
    send(16'hBEEF, 1'b1);
    wait_drain(50);
    @(negedge clk);
    check("single_s_ready", {31'b0, s_ready}, 32'd1);

    // Reset mid-drain of a four-word frame
    sink_mode = 3;
    for (int i = 1; i <= 4; i++) send(WIDTH'(16'h0040 + i), i == 4);
    repeat (3) @(negedge clk);
    check("pre_rst_valid", {31'b0, m_valid}, 32'd1);
    rst = 1'b0;
    exp_q.delete();
    chunk_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_valid", {31'b0, m_valid}, 32'd0);
    check("post_rst_s_ready", {31'b0, s_ready}, 32'd1);
    check("post_rst_empty", {31'b0, lifo_empty}, 32'd1);
    sink_mode = 0;
    send(16'h0101, 1'b0);
    send(16'h0202, 1'b1);
    wait_drain(50);

    // Random frames with random gaps and backpressure
    sink_mode = 2;
    split_cnt = 0; split_exp = 0;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        send(WIDTH'($urandom), i == len - 1);
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    end
    wait_drain(2000);
    check("rand_split_count", split_cnt, split_exp);
    sink_mode = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
